// File: rtl/cl_pairhmm_job_scheduler.sv
// cl_pairhmm_job_scheduler
//   Feeds a stream of PairHMM work requests to NUM_WG workgroups and merges their
//   final results back into one tagged stream. A job goes to the first workgroup at or
//   after the round-robin pointer that still has a free credit. Jobs and results are
//   counted against a programmed total, and completion is flagged.
//
// Ports
//   clock_i, reset_ni              clock, async active-low reset
//   start_i, job_count_i           start pulse and total job count for the run
//   job_t{data,valid,ready}        upstream request stream
//   wg_job_t{data,valid,ready}     shared request bus, one-hot valid per workgroup
//   wg_res_t{data,valid,ready}     per-workgroup result streams (flat data bus)
//   res_t{data,valid,ready}, res_wg_o   merged result stream and its source workgroup
//   busy_o, done_o, err_o          RUN, DONE, sticky over-count result
//   jobs_sent_o, results_rcvd_o    progress counters

// Per-workgroup outstanding-job counter. A dispatch and a return in the same cycle
// cancel. A return at zero is ignored, so a stray result cannot underflow the counter.
module cl_pairhmm_credit_ctr #(
    parameter int CR_W = 3
) (
    input  logic            clock_i,
    input  logic            reset_ni,
    input  logic            inc,
    input  logic            dec,
    output logic [CR_W-1:0] credit
);
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni)                          credit <= '0;
        else if (inc && !dec)                   credit <= credit + 1'b1;
        else if (dec && !inc && credit != '0)   credit <= credit - 1'b1;
    end
endmodule

module cl_pairhmm_job_scheduler #(
    parameter  int NUM_WG  = 2,
    parameter  int JOB_W   = 224,
    parameter  int RES_W   = 64,
    parameter  int MAX_OUT = 4,
    parameter  int CNT_W   = 16,
    localparam int WG_W    = (NUM_WG > 1) ? $clog2(NUM_WG) : 1
) (
    input  logic                    clock_i,
    input  logic                    reset_ni,
    input  logic                    start_i,
    input  logic [CNT_W-1:0]        job_count_i,
    input  logic [JOB_W-1:0]        job_tdata_i,
    input  logic                    job_tvalid_i,
    output logic                    job_tready_o,
    output logic [JOB_W-1:0]        wg_job_tdata_o,
    output logic [NUM_WG-1:0]       wg_job_tvalid_o,
    input  logic [NUM_WG-1:0]       wg_job_tready_i,
    input  logic [NUM_WG*RES_W-1:0] wg_res_tdata_i,
    input  logic [NUM_WG-1:0]       wg_res_tvalid_i,
    output logic [NUM_WG-1:0]       wg_res_tready_o,
    output logic [RES_W-1:0]        res_tdata_o,
    output logic [WG_W-1:0]         res_wg_o,
    output logic                    res_tvalid_o,
    input  logic                    res_tready_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [CNT_W-1:0]        jobs_sent_o,
    output logic [CNT_W-1:0]        results_rcvd_o
);
    localparam int CR_W = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    typedef struct packed {
        logic             vld;
        logic [WG_W-1:0]  wg;
        logic [JOB_W-1:0] data;
    } job_slot_t;

    typedef struct packed {
        logic             vld;
        logic [WG_W-1:0]  wg;
        logic [RES_W-1:0] data;
    } res_slot_t;

    state_t                      state;
    logic [CNT_W-1:0]            cnt;
    logic [CNT_W-1:0]            jobs_acc;   // jobs taken from upstream this run
    job_slot_t                   jslot;
    res_slot_t                   rslot;
    logic [WG_W-1:0]             jptr, gptr, jsel, gsel;
    logic                        jsel_ok, gsel_ok;
    logic [NUM_WG-1:0][CR_W-1:0] credit;
    logic [NUM_WG-1:0]           elig, cr_inc, cr_dec;
    logic                        run, jdrain, jin, rdrain, rhs;

    function automatic logic [WG_W-1:0] wrap_inc(input logic [WG_W-1:0] p);
        if (int'(p) >= NUM_WG - 1) return '0;
        return p + 1'b1;
    endfunction

    assign run = (state == S_RUN);

    // A job sitting in the dispatch register already owns a credit on its target.
    // Counting it here keeps a back-to-back accept from overcommitting that workgroup.
    always_comb begin
        for (int k = 0; k < NUM_WG; k++)
            elig[k] = (int'(credit[k]) + int'(jslot.vld && (jslot.wg == WG_W'(k)))) < MAX_OUT;
    end

    // The loop walks from the farthest offset down, so the nearest candidate
    // at or after the pointer is the last one written and wins.
    always_comb begin
        int idx;
        idx     = 0;
        jsel    = '0;
        jsel_ok = 1'b0;
        for (int i = NUM_WG - 1; i >= 0; i--) begin
            idx = int'(jptr) + i;
            if (idx >= NUM_WG) idx = idx - NUM_WG;
            if (elig[idx]) begin
                jsel    = WG_W'(idx);
                jsel_ok = 1'b1;
            end
        end
    end

    always_comb begin
        int idx;
        idx     = 0;
        gsel    = '0;
        gsel_ok = 1'b0;
        for (int i = NUM_WG - 1; i >= 0; i--) begin
            idx = int'(gptr) + i;
            if (idx >= NUM_WG) idx = idx - NUM_WG;
            if (wg_res_tvalid_i[idx]) begin
                gsel    = WG_W'(idx);
                gsel_ok = 1'b1;
            end
        end
    end

    assign jdrain          = jslot.vld && wg_job_tready_i[jslot.wg];
    assign job_tready_o    = run && (!jslot.vld || jdrain) && (jobs_acc < cnt) && jsel_ok;
    assign jin             = job_tvalid_i && job_tready_o;
    assign wg_job_tdata_o  = jslot.data;
    assign wg_job_tvalid_o = jslot.vld ? (NUM_WG'(1) << jslot.wg) : '0;

    // Result ready is gated by reset so nothing is acknowledged while it is held.
    assign rdrain          = rslot.vld && res_tready_i;
    assign rhs             = reset_ni && gsel_ok && (!rslot.vld || rdrain);
    assign wg_res_tready_o = rhs ? (NUM_WG'(1) << gsel) : '0;
    assign res_tdata_o     = rslot.data;
    assign res_wg_o        = rslot.wg;
    assign res_tvalid_o    = rslot.vld;

    for (genvar k = 0; k < NUM_WG; k++) begin : g_cr
        assign cr_inc[k] = jdrain && (jslot.wg == WG_W'(k));
        assign cr_dec[k] = rhs && (gsel == WG_W'(k));
        cl_pairhmm_credit_ctr #(.CR_W(CR_W)) u_cr (
            .clock_i  (clock_i),
            .reset_ni (reset_ni),
            .inc      (cr_inc[k]),
            .dec      (cr_dec[k]),
            .credit   (credit[k])
        );
    end

    // Dispatch and merge registers with their round-robin pointers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            jslot <= '0;
            rslot <= '0;
            jptr  <= '0;
            gptr  <= '0;
        end else begin
            if (jdrain) jslot.vld <= 1'b0;
            if (jin) begin
                jslot.vld  <= 1'b1;
                jslot.data <= job_tdata_i;
                jslot.wg   <= jsel;
                jptr       <= wrap_inc(jsel);
            end
            if (rdrain) rslot.vld <= 1'b0;
            if (rhs) begin
                rslot.vld  <= 1'b1;
                rslot.data <= wg_res_tdata_i[int'(gsel)*RES_W +: RES_W];
                rslot.wg   <= gsel;
                gptr       <= wrap_inc(gsel);
            end
        end
    end

    // Run control. The counter updates come first; a start that opens a new
    // run then overrides them with the cleared values.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state          <= S_IDLE;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
            cnt            <= '0;
            jobs_acc       <= '0;
            jobs_sent_o    <= '0;
            results_rcvd_o <= '0;
        end else begin
            if (jdrain) jobs_sent_o <= jobs_sent_o + 1'b1;
            if (jin)    jobs_acc    <= jobs_acc + 1'b1;
            if (rhs) begin
                // Results outside a run, or beyond the programmed total, still pass
                // through, but they are not counted and they raise the error flag.
                if (run && (results_rcvd_o < cnt)) results_rcvd_o <= results_rcvd_o + 1'b1;
                else                               err_o          <= 1'b1;
            end
            case (state)
                S_RUN: begin
                    if (results_rcvd_o == cnt) begin
                        state  <= S_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    if (start_i) begin
                        state          <= S_RUN;
                        busy_o         <= 1'b1;
                        done_o         <= 1'b0;
                        err_o          <= 1'b0;
                        cnt            <= job_count_i;
                        jobs_acc       <= '0;
                        jobs_sent_o    <= '0;
                        results_rcvd_o <= '0;
                    end
                end
            endcase
        end
    end
endmodule
